// File: rtl/fp_pkg.sv
// Shared FP32 constants, flag positions, divider FSM states and field helpers
// for the F-extension arithmetic units.
package fp_pkg;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam int          FP_EXP_BIAS  = 127;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // 24 significand bits + guard + round; the final remainder supplies sticky.
    localparam int FP_DIV_QBITS = 26;
    localparam int FP_DIV_LAT   = FP_DIV_QBITS + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        ROUND = 2'd2,
        WB    = 2'd3
    } div_state_t;

    function automatic logic fp_sign(input logic [31:0] x);
        return x[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[30:23];
    endfunction

    function automatic logic [22:0] fp_frac(input logic [31:0] x);
        return x[22:0];
    endfunction

endpackage

// File: rtl/fp_div_iter_if.sv
// Operand/launch and register-file write-port bundle of the iterative divider.
interface fp_div_iter_if;
    // start is taken on a rising edge where busy is low, otherwise dropped;
    // we is a single-cycle qualifier for write_addressf, data_inf and fflags.
    logic        start;
    logic [31:0] src1f;
    logic [31:0] src2f;
    logic [4:0]  rd_in;
    logic        busy;
    logic        we;
    logic [4:0]  write_addressf;
    logic [31:0] data_inf;
    logic [4:0]  fflags;

    modport master (
        output start, src1f, src2f, rd_in,
        input  busy, we, write_addressf, data_inf, fflags
    );

    modport slave (
        input  start, src1f, src2f, rd_in,
        output busy, we, write_addressf, data_inf, fflags
    );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational RNE round and pack of a normalised quotient into FP32,
// with overflow to Inf and flush-to-zero on underflow. Returns {OF,UF,NX}.
module fp_round_pack #(
    parameter int QBITS = 26
) (
    input  logic             i_sign,
    input  logic [9:0]       i_exp,
    input  logic [QBITS-1:0] i_q,
    input  logic             i_sticky,
    output logic [31:0]      o_res,
    output logic [2:0]       o_flags
);

    logic [23:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [24:0] w_sum;
    logic [9:0]  w_exp_r;
    logic [22:0] w_frac;
    logic        w_nx;

    assign w_mant   = i_q[QBITS-1 -: 24];
    assign w_guard  = i_q[QBITS-25];
    assign w_sticky = (|i_q[QBITS-26:0]) | i_sticky;
    assign w_inc    = w_guard & (w_sticky | w_mant[0]);
    assign w_sum    = {1'b0, w_mant} + {24'b0, w_inc};
    // A carry out of the significand can only leave 1.000..0, so shift and bump.
    assign w_exp_r  = i_exp + {9'b0, w_sum[24]};
    assign w_frac   = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    assign w_nx     = w_guard | w_sticky;

    always_comb begin
        o_res   = {i_sign, w_exp_r[7:0], w_frac};
        o_flags = {2'b00, w_nx};
        if ($signed(w_exp_r) >= 10'sd255) begin
            o_res   = {i_sign, 8'hFF, 23'b0};
            o_flags = 3'b101;
        end else if ($signed(w_exp_r) <= 10'sd0) begin
            o_res   = {i_sign, 31'b0};
            o_flags = 3'b011;
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative FP32 divider: restoring division one quotient bit per cycle,
// fixed start-to-write latency, result written straight to the FP register file.
module fp_div_iter
    import fp_pkg::*;
#(
    parameter int QBITS = FP_DIV_QBITS
) (
    input  logic            clk,
    input  logic            rst,
    fp_div_iter_if.slave    bus,
    output div_state_t      o_dbg_state
);

    div_state_t       r_state;
    div_state_t       w_next;
    logic [4:0]       r_cnt;
    logic [25:0]      r_rem;
    logic [23:0]      r_mb;
    logic [QBITS-1:0] r_q;
    logic [9:0]       r_exp;
    logic             r_sign;
    logic [4:0]       r_rd;
    logic             r_special;
    logic [31:0]      r_spec_res;
    logic [4:0]       r_spec_flags;
    logic [31:0]      r_data;
    logic [4:0]       r_flags;
    logic [4:0]       r_addr;

    logic [7:0]  w_e1, w_e2;
    logic [22:0] w_f1, w_f2;
    logic        w_sign;
    logic        w_nan1, w_nan2, w_snan1, w_snan2;
    logic        w_inf1, w_inf2, w_zero1, w_zero2;
    logic [23:0] w_ma, w_mb;
    logic        w_adj;
    logic [9:0]  w_exp;
    logic        w_special;
    logic [31:0] w_spec_res;
    logic [4:0]  w_spec_flags;
    logic        w_ge;
    logic [25:0] w_rem_sub;
    logic [31:0] w_rp_res;
    logic [2:0]  w_rp_flags;

    assign w_e1    = fp_exp(bus.src1f);
    assign w_e2    = fp_exp(bus.src2f);
    assign w_f1    = fp_frac(bus.src1f);
    assign w_f2    = fp_frac(bus.src2f);
    assign w_sign  = fp_sign(bus.src1f) ^ fp_sign(bus.src2f);
    assign w_nan1  = (w_e1 == 8'hFF) && (w_f1 != 23'b0);
    assign w_nan2  = (w_e2 == 8'hFF) && (w_f2 != 23'b0);
    assign w_snan1 = w_nan1 && !w_f1[22];
    assign w_snan2 = w_nan2 && !w_f2[22];
    assign w_inf1  = (w_e1 == 8'hFF) && (w_f1 == 23'b0);
    assign w_inf2  = (w_e2 == 8'hFF) && (w_f2 == 23'b0);
    // Subnormal operands count as zero.
    assign w_zero1 = (w_e1 == 8'h00);
    assign w_zero2 = (w_e2 == 8'h00);

    assign w_ma  = {1'b1, w_f1};
    assign w_mb  = {1'b1, w_f2};
    assign w_adj = (w_ma < w_mb);
    assign w_exp = {2'b00, w_e1} - {2'b00, w_e2} + 10'(FP_EXP_BIAS) - {9'b0, w_adj};

    always_comb begin
        w_special    = 1'b0;
        w_spec_res   = 32'b0;
        w_spec_flags = 5'b0;
        if (w_nan1 || w_nan2) begin
            w_special             = 1'b1;
            w_spec_res            = FP_CANON_NAN;
            w_spec_flags[FLAG_NV] = w_snan1 | w_snan2;
        end else if ((w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
            w_special             = 1'b1;
            w_spec_res            = FP_CANON_NAN;
            w_spec_flags[FLAG_NV] = 1'b1;
        end else if (w_zero2 && !w_inf1) begin
            w_special             = 1'b1;
            w_spec_res            = {w_sign, 8'hFF, 23'b0};
            w_spec_flags[FLAG_DZ] = 1'b1;
        end else if (w_inf1) begin
            w_special  = 1'b1;
            w_spec_res = {w_sign, 8'hFF, 23'b0};
        end else if (w_inf2 || w_zero1) begin
            w_special  = 1'b1;
            w_spec_res = {w_sign, 31'b0};
        end
    end

    // Remainder stays below 2*mb, so 26 bits never overflow.
    assign w_ge      = (r_rem >= {2'b00, r_mb});
    assign w_rem_sub = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;

    fp_round_pack #(.QBITS(QBITS)) u_round_pack (
        .i_sign   (r_sign),
        .i_exp    (r_exp),
        .i_q      (r_q),
        .i_sticky (|r_rem),
        .o_res    (w_rp_res),
        .o_flags  (w_rp_flags)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = ITER;
            ITER:    if (r_cnt == 5'(QBITS - 1)) w_next = ROUND;
            ROUND:   w_next = WB;
            WB:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= 32'b0;
            r_flags <= 5'b0;
            r_addr  <= 5'b0;
            r_cnt   <= 5'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_rem        <= w_adj ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
                        r_mb         <= w_mb;
                        r_q          <= '0;
                        r_exp        <= w_exp;
                        r_sign       <= w_sign;
                        r_rd         <= bus.rd_in;
                        r_special    <= w_special;
                        r_spec_res   <= w_spec_res;
                        r_spec_flags <= w_spec_flags;
                        r_cnt        <= 5'b0;
                    end
                end
                ITER: begin
                    r_q   <= {r_q[QBITS-2:0], w_ge};
                    r_rem <= w_rem_sub << 1;
                    r_cnt <= r_cnt + 5'd1;
                end
                ROUND: begin
                    r_data  <= r_special ? r_spec_res : w_rp_res;
                    r_flags <= r_special ? r_spec_flags : {2'b00, w_rp_flags};
                    r_addr  <= r_rd;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = (r_state != IDLE);
    assign bus.we             = (r_state == WB);
    assign bus.write_addressf = r_addr;
    assign bus.data_inf       = r_data;
    assign bus.fflags         = (r_state == WB) ? r_flags : 5'b0;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_fp_div_iter.sv
// Self-checking bench for fp_div_iter: directed vectors, an arithmetic model
// for random normal operands, handshake, back-to-back and reset-abort checks.
module tb_fp_div_iter;
    import fp_pkg::*;

    localparam int LAT = FP_DIV_LAT;
    localparam int W   = 74;   // {due_cycle[31:0], rd[4:0], flags[4:0], res[31:0]}

    logic       clk = 1'b0;
    logic       rst;
    div_state_t dbg_state;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         n_writes = 0;
    logic [W-1:0] exp_q[$];

    fp_div_iter_if bus();

    fp_div_iter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every write is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.we === 1'b1) begin
            logic [W-1:0] e;
            n_writes++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write cyc=%0d data=%h addr=%0d", cyc, bus.data_inf, bus.write_addressf);
            end else begin
                e = exp_q.pop_front();
                if ({bus.write_addressf, bus.fflags, bus.data_inf} !== e[41:0]) begin
                    n_fail++;
                    $display("FAIL write_value got addr=%0d flags=%h data=%h want addr=%0d flags=%h data=%h",
                             bus.write_addressf, bus.fflags, bus.data_inf, e[41:37], e[36:32], e[31:0]);
                end
                n_tests++;
                if (cyc != int'(e[73:42])) begin
                    n_fail++;
                    $display("FAIL write_cycle got %0d want %0d", cyc, e[73:42]);
                end
            end
        end
    end

    function automatic logic [36:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic [49:0] num, q, rem, low, half;
        logic [23:0] ma, mb;
        logic [24:0] m;
        int          e, drop;
        logic        up, nx;
        ma   = {1'b1, a[22:0]};
        mb   = {1'b1, b[22:0]};
        num  = {ma, 26'b0};
        q    = num / {26'b0, mb};
        rem  = num % {26'b0, mb};
        e    = 32'(a[30:23]) - 32'(b[30:23]) + 127;
        if (q[26]) drop = 3;
        else begin
            drop = 2;
            e    = e - 1;
        end
        m    = 25'(q >> drop);
        low  = q & ((50'd1 << drop) - 50'd1);
        half = 50'd1 << (drop - 1);
        nx   = (low != 0) || (rem != 0);
        up   = (low > half) || ((low == half) && ((rem != 0) || m[0]));
        m    = m + 25'(up);
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {4'b0, nx, a[31] ^ b[31], e[7:0], m[22:0]};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] eres, input logic [4:0] eflg);
        bus.start = 1'b1;
        bus.src1f = a;
        bus.src2f = b;
        bus.rd_in = rd;
        exp_q.push_back({32'(cyc + LAT), rd, eflg, eres});
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && bus.busy === 1'b0) break;
            @(posedge clk); #1;
        end
        n_tests++;
        if (i == 200) begin
            n_fail++;
            $display("FAIL wait_idle_timeout pending=%0d busy=%b want pending=0 busy=0", exp_q.size(), bus.busy);
            exp_q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] eres, input logic [4:0] eflg);
        issue(a, b, rd, eres, eflg);
        wait_idle();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.src1f = 32'b0;
        bus.src2f = 32'b0;
        bus.rd_in = 5'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.we, bus.write_addressf, bus.fflags} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy=%b we=%b addr=%0d flags=%h want 0", bus.busy, bus.we, bus.write_addressf, bus.fflags);
        end
        n_tests++;
        if (bus.data_inf !== 32'b0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 00000000", bus.data_inf);
        end
        n_tests++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_exact();
        int bad = 0;
        int w0 = n_writes;
        issue(32'h40C00000, 32'h40000000, 5'd5, 32'h40400000, 5'h00);
        for (int k = 1; k <= 29; k++) begin
            if (bus.busy !== (k <= 28)) bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL busy_window got %0d wrong cycles want 0", bad);
        end
        wait_idle();
        n_tests++;
        if (n_writes - w0 != 1) begin
            n_fail++;
            $display("FAIL exact_we_count got %0d want 1", n_writes - w0);
        end
    endtask

    task automatic test_rounding();
        run_op(32'h3F800000, 32'h40400000, 5'd1, 32'h3EAAAAAB, 5'h01);
        run_op(32'hBF800000, 32'h40400000, 5'd2, 32'hBEAAAAAB, 5'h01);
    endtask

    task automatic test_specials();
        run_op(32'h3F800000, 32'h00000000, 5'd3, 32'h7F800000, 5'h08);
        run_op(32'hBF800000, 32'h00000000, 5'd4, 32'hFF800000, 5'h08);
        run_op(32'h00000000, 32'h00000000, 5'd6, 32'h7FC00000, 5'h10);
        run_op(32'h7F800000, 32'h40000000, 5'd7, 32'h7F800000, 5'h00);
        run_op(32'h7F800000, 32'hFF800000, 5'd8, 32'h7FC00000, 5'h10);
        run_op(32'h7FC00001, 32'h3F800000, 5'd9, 32'h7FC00000, 5'h00);
        run_op(32'h3F800000, 32'h7F800001, 5'd10, 32'h7FC00000, 5'h10);
        run_op(32'h3F800000, 32'hFF800000, 5'd11, 32'h80000000, 5'h00);
        run_op(32'h80000000, 32'h40000000, 5'd12, 32'h80000000, 5'h00);
    endtask

    task automatic test_range();
        run_op(32'h7F7FFFFF, 32'h3F000000, 5'd13, 32'h7F800000, 5'h05);
        run_op(32'h00800000, 32'h40000000, 5'd14, 32'h00000000, 5'h03);
        run_op(32'h00000001, 32'h3F800000, 5'd15, 32'h00000000, 5'h00);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, b;
            logic [36:0] m;
            a = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
            b = {1'($urandom_range(1, 0)), 8'($urandom_range(154, 100)), 23'($urandom)};
            m = model_div(a, b);
            run_op(a, b, 5'($urandom_range(31, 0)), m[31:0], m[36:32]);
        end
    endtask

    task automatic test_ignored_start();
        int w0 = n_writes;
        issue(32'h41200000, 32'h40A00000, 5'd16, 32'h40000000, 5'h00);
        repeat (4) begin
            @(posedge clk); #1;
        end
        bus.start = 1'b1;
        bus.src1f = 32'h3F800000;
        bus.src2f = 32'h40400000;
        bus.rd_in = 5'd17;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (35) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (n_writes - w0 != 1) begin
            n_fail++;
            $display("FAIL ignored_start_writes got %0d want 1", n_writes - w0);
        end
    endtask

    task automatic test_back_to_back();
        int w0 = n_writes;
        int i;
        issue(32'h40400000, 32'h40400000, 5'd18, 32'h3F800000, 5'h00);
        for (i = 0; i < 60; i++) begin
            if (bus.we === 1'b1) break;
            @(posedge clk); #1;
        end
        n_tests++;
        if (i == 60) begin
            n_fail++;
            $display("FAIL b2b_first_write got none want we within 60 cycles");
        end
        @(posedge clk); #1;
        issue(32'hC1000000, 32'h40800000, 5'd19, 32'hC0000000, 5'h00);
        wait_idle();
        n_tests++;
        if (n_writes - w0 != 2) begin
            n_fail++;
            $display("FAIL b2b_writes got %0d want 2", n_writes - w0);
        end
    endtask

    task automatic test_reset_mid_op();
        int w0;
        issue(32'h40C00000, 32'h40000000, 5'd20, 32'h40400000, 5'h00);
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        w0  = n_writes;
        n_tests++;
        if (bus.busy !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL abort_busy got busy=%b state=%0d want busy=0 state=0", bus.busy, dbg_state);
        end
        repeat (40) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (n_writes != w0) begin
            n_fail++;
            $display("FAIL abort_no_write got %0d writes want 0", n_writes - w0);
        end
        run_op(32'h40000000, 32'h40800000, 5'd21, 32'h3F000000, 5'h00);
    endtask

    initial begin
        test_reset();
        test_exact();
        test_rounding();
        test_specials();
        test_range();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Iterative single-precision (FP32) divider for the F-extension datapath.
- Accepts two operands read from the FP register file plus a destination index.
- Produces a one-cycle write strobe, address and result that drive the FP register file write port (we, write_addressf, data_inf) directly.
- Multi-cycle, one operation in flight, fixed latency, round-to-nearest-even only.

Parameters:
- QBITS, 26, quotient bits generated: 24 significand + guard + round; the remainder supplies sticky.
- LAT, QBITS+2, start-to-write latency in cycles; derived, do not override.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  launch request; accepted only when busy=0
- src1f  in  32  dividend, IEEE-754 binary32
- src2f  in  32  divisor, IEEE-754 binary32
- rd_in  in  5  destination FP register index
- busy  out  1  high from the cycle after acceptance through the write cycle
- we  out  1  one-cycle write strobe to the FP register file
- write_addressf  out  5  destination index, valid with we
- data_inf  out  32  result, valid with we
- fflags  out  5  {NV,DZ,OF,UF,NX}, valid with we, zero otherwise

Behaviour:
- Reset: busy=0, we=0, write_addressf=0, data_inf=0, fflags=0, FSM to IDLE.
- Reset mid-operation aborts the operation; no write is issued.
- FSM states and transitions:
  - IDLE: on start, latch operands and rd_in at T and go to ITER.
  - ITER: one quotient bit per cycle for QBITS cycles, T+1..T+QBITS.
  - ROUND: cycle T+QBITS+1, normalise and round.
  - WB: we=1 during cycle T+LAT (T+28), then back to IDLE.
- Back-to-back: start may be accepted in the cycle after WB.
- start while busy=1 is ignored; no queuing.
- Subnormal inputs are treated as signed zero (DAZ). Subnormal results flush to signed zero (FTZ) with UF=1 and NX=1.
- Sign of the result = s1 XOR s2. Exception: the NaN result is canonical 0x7FC00000.
- Special cases: resolved at latch time but still written at T+LAT (fixed latency):
  - any NaN operand, 0/0 or Inf/Inf → 0x7FC00000. NV=1 only for sNaN, 0/0 and Inf/Inf.
  - finite nonzero / 0 → signed Inf, DZ=1.
  - Inf / finite → signed Inf, no flags.
  - finite / Inf → signed zero, no flags.
  - 0 / finite nonzero → signed zero, no flags.
- Normal path, significands with hidden bit (24b):
  - if ma<mb, shift the dividend left 1 and decrement the exponent.
  - restoring division: q_i=(r>=mb); if set, r=r-mb; then r<<=1.
  - exponent = e1 - e2 + 127 (+adjust), 10-bit signed arithmetic.
- Rounding (RNE):
  - guard = q[1]; sticky = q[0] OR (r!=0).
  - increment if guard AND (sticky OR lsb).
  - carry-out renormalises and increments the exponent.
  - NX = guard OR sticky.
- Exponent range:
  - exponent >= 255 after rounding → signed Inf, OF=1, NX=1.
  - exponent <= 0 → signed zero, UF=1, NX=1.

Decomposition:
- Package fp_pkg holds:
  - FP_CANON_NAN = 32'h7FC00000, FP_EXP_BIAS = 127.
  - flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0.
  - FSM state typedef {IDLE, ITER, ROUND, WB}.
  - field-extract helpers for sign, exponent and fraction.
- One sub-module: fp_round_pack. It is combinational: it takes sign, 10-bit exponent, 26-bit quotient and the sticky bit, and produces the 32-bit result and {OF,UF,NX}. It is reusable by future FP units.
- Top level: FSM, iteration datapath, special-case decode.

Test Plan:
- Exact divide: 0x40C00000 / 0x40000000 (6.0/2.0), rd_in=5, start at T → we=1 only at T+28, write_addressf=5, data_inf=0x40400000, fflags=0; busy high T+1..T+28.
- Rounding: 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, fflags=0x01 (NX); 0xBF800000 / 0x40400000 → 0xBEAAAAAB.
- Specials, each at T+28:
  - 0x3F800000 / 0x00000000 → 0x7F800000, fflags=0x08.
  - 0x00000000 / 0x00000000 → 0x7FC00000, fflags=0x10.
  - 0x7F800000 / 0x40000000 → 0x7F800000, fflags=0.
- Range limits:
  - 0x7F7FFFFF / 0x3F000000 → 0x7F800000, fflags=0x05.
  - 0x00800000 / 0x40000000 → 0x00000000, fflags=0x03.
  - subnormal dividend 0x00000001 / 0x3F800000 → 0x00000000, fflags=0.
- Handshake: second start at T+5 with different operands → ignored, single write at T+28. New start in the cycle after WB → write exactly 28 cycles later.
- Reset mid-op: rst=1 at T+10 for one cycle → busy=0 at T+11, no we pulse ever. A following start proceeds normally.
